// File: rtl/mdio_master.sv
// MDIO (clause 22) management master: one 64-bit frame per accepted command.
// Each bit period is 2*CLK_DIV clk cycles, mdc low for the first half and high for the second.
module mdio_master #(
  parameter int unsigned CLK_DIV = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdRead,
  input  logic [4:0]  cmdPhyAddr,
  input  logic [4:0]  cmdRegAddr,
  input  logic [15:0] cmdWrData,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic        rspTaErr,
  output logic        busy,
  output logic        mdc,
  output logic        mdioOut,
  output logic        mdioT,
  input  logic        mdioIn
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

  localparam logic [8:0] HALF = 9'(CLK_DIV);
  localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

  state_t      state;
  logic [8:0]  phase;
  logic [5:0]  bit_cnt;
  logic [5:0]  next_bit;
  logic        rd;
  logic [31:0] frame_word;
  logic [15:0] rd_shift;
  logic        ta_err;

  assign next_bit = bit_cnt + 6'd1;

  // Everything after the preamble (ST, OP, addresses, TA, data) lives in frame_word;
  // frame bit b >= 32 is frame_word[63-b], i.e. the inverted low five bits of b.
  // NOTE: all state here is updated with non-blocking assignments, so every
  // right-hand side reads the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      rd         <= 1'b0;
      frame_word <= '0;
      rd_shift   <= '0;
      ta_err     <= 1'b0;
      mdc        <= 1'b0;
      mdioOut    <= 1'b1;
      mdioT      <= 1'b1;
      busy       <= 1'b0;
      cmdReady   <= 1'b0;
      rspValid   <= 1'b0;
      rspData    <= '0;
      rspTaErr   <= 1'b0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        IDLE: begin
          cmdReady <= 1'b1;
          if (cmdValid && cmdReady) begin
            rd         <= cmdRead;
            frame_word <= cmdRead
                          ? {4'b0110, cmdPhyAddr, cmdRegAddr, 2'b11, 16'hFFFF}
                          : {4'b0101, cmdPhyAddr, cmdRegAddr, 2'b10, cmdWrData};
            rd_shift   <= '0;
            ta_err     <= 1'b0;
            phase      <= '0;
            bit_cnt    <= '0;
            state      <= PRE;
            busy       <= 1'b1;
            cmdReady   <= 1'b0;
            mdc        <= 1'b0;
            mdioOut    <= 1'b1;
            mdioT      <= 1'b0;
          end
        end

        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          cmdReady <= 1'b1;
        end

        default: begin
          // The PHY's bit is taken on the first mdc-high cycle.
          if (rd && phase == HALF) begin
            if (state == TA && bit_cnt[0]) ta_err <= mdioIn;
            if (state == DATA) rd_shift <= {rd_shift[14:0], mdioIn};
          end

          if (phase != LAST) begin
            phase <= phase + 9'd1;
            if (phase == HALF - 9'd1) mdc <= 1'b1;
          end else begin
            phase <= '0;
            mdc   <= 1'b0;
            if (bit_cnt == 6'd63) begin
              state    <= DONE;
              mdioOut  <= 1'b1;
              mdioT    <= 1'b1;
              rspValid <= 1'b1;
              rspData  <= rd ? rd_shift : 16'h0000;
              rspTaErr <= rd & ta_err;
            end else begin
              bit_cnt <= next_bit;
              mdioOut <= (next_bit < 6'd32) ? 1'b1 : frame_word[~next_bit[4:0]];
              mdioT   <= rd && (next_bit >= 6'd46);
              if (next_bit < 6'd32)      state <= PRE;
              else if (next_bit < 6'd46) state <= HDR;
              else if (next_bit < 6'd48) state <= TA;
              else                       state <= DATA;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: frames are captured bit by bit and compared
// against a stream assembled from the frame format; a PHY model answers reads.
module tb_mdio_master;

  localparam int D  = 2;
  localparam int DS = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cmdValid = 1'b0, cmdRead = 1'b0;
  logic [4:0]  cmdPhyAddr = '0, cmdRegAddr = '0;
  logic [15:0] cmdWrData = '0;
  logic        cmdReady, rspValid, rspTaErr, busy, mdc, mdioOut, mdioT;
  logic [15:0] rspData;
  logic        mdioIn = 1'b1;

  logic        s_cmdValid = 1'b0, s_cmdRead = 1'b0;
  logic [4:0]  s_cmdPhyAddr = '0, s_cmdRegAddr = '0;
  logic [15:0] s_cmdWrData = '0;
  logic        s_cmdReady, s_rspValid, s_rspTaErr, s_busy, s_mdc, s_mdioOut, s_mdioT;
  logic [15:0] s_rspData;
  logic        s_mdioIn;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;
  assign s_mdioIn = s_mdioOut;

  mdio_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdRead(cmdRead),
    .cmdPhyAddr(cmdPhyAddr), .cmdRegAddr(cmdRegAddr), .cmdWrData(cmdWrData),
    .rspValid(rspValid), .rspData(rspData), .rspTaErr(rspTaErr), .busy(busy),
    .mdc(mdc), .mdioOut(mdioOut), .mdioT(mdioT), .mdioIn(mdioIn)
  );

  mdio_master #(.CLK_DIV(DS)) dut_slow (
    .clk(clk), .rst(rst),
    .cmdValid(s_cmdValid), .cmdReady(s_cmdReady), .cmdRead(s_cmdRead),
    .cmdPhyAddr(s_cmdPhyAddr), .cmdRegAddr(s_cmdRegAddr), .cmdWrData(s_cmdWrData),
    .rspValid(s_rspValid), .rspData(s_rspData), .rspTaErr(s_rspTaErr), .busy(s_busy),
    .mdc(s_mdc), .mdioOut(s_mdioOut), .mdioT(s_mdioT), .mdioIn(s_mdioIn)
  );

  // Whole frame, bit 0 at [63]; the TA/data bits of a read are don't-care on mdioOut.
  function automatic logic [63:0] exp_stream(input logic rd, input logic [4:0] pa,
                                             input logic [4:0] ra, input logic [15:0] wd);
    return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), pa, ra,
            (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wd)};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({mdc, mdioT, mdioOut, busy, rspValid, rspTaErr, cmdReady} !== 7'b0110000 || rspData !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_state: mdc/T/out/busy/rv/taerr/rdy=%b rspData=%h, want 0110000 0000",
               {mdc, mdioT, mdioOut, busy, rspValid, rspTaErr, cmdReady}, rspData);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (cmdReady !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: cmdReady=%b want 1", cmdReady);
    end
  endtask

  // Issue one command at a negedge and follow the frame cycle by cycle to completion.
  task automatic run_frame(input string name, input logic rd, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input logic ta2,
                           input logic [15:0] pd, input bit keep_valid, output int acc_wait);
    logic [63:0] got_out, got_t, exp_out, exp_t, mask;
    logic [15:0] exp_data;
    int bit_i, ph, mdc_bad, hold_bad, early_rv, rdy_bad, busy_bad;
    got_out = '0; got_t = '0;
    mdc_bad = 0; hold_bad = 0; early_rv = 0; rdy_bad = 0; busy_bad = 0;
    cmdValid = 1'b1; cmdRead = rd; cmdPhyAddr = pa; cmdRegAddr = ra; cmdWrData = wd;
    acc_wait = 0;
    while (cmdReady !== 1'b1 && acc_wait < 50) begin
      @(negedge clk);
      acc_wait++;
    end
    compared++;
    if (cmdReady !== 1'b1) begin
      mismatched++;
      $display("FAIL %s accept: cmdReady=%b after %0d cycles, want 1", name, cmdReady, acc_wait);
      cmdValid = 1'b0;
      return;
    end
    @(negedge clk);
    cmdValid   = keep_valid;
    cmdRead    = 1'($urandom);
    cmdPhyAddr = 5'($urandom);
    cmdRegAddr = 5'($urandom);
    cmdWrData  = 16'($urandom);
    for (int c = 0; c < 128 * D; c++) begin
      bit_i = c / (2 * D);
      ph    = c % (2 * D);
      if (mdc !== (ph >= D)) mdc_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (rspValid !== 1'b0) early_rv++;
      if (cmdReady !== 1'b0) rdy_bad++;
      if (ph == 0) begin
        got_out[63 - bit_i] = mdioOut;
        got_t[63 - bit_i]   = mdioT;
        if (mdioT === 1'b0)  mdioIn = mdioOut;
        else if (bit_i == 47) mdioIn = ta2;
        else if (bit_i >= 48) mdioIn = pd[63 - bit_i];
        else                  mdioIn = 1'b1;
      end else if (mdioOut !== got_out[63 - bit_i] || mdioT !== got_t[63 - bit_i]) begin
        hold_bad++;
      end
      @(negedge clk);
    end
    mdioIn = 1'b1;

    exp_out  = exp_stream(rd, pa, ra, wd);
    mask     = rd ? 64'hFFFF_FFFF_FFFC_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
    exp_t    = rd ? 64'h0000_0000_0003_FFFF : 64'h0;
    exp_data = rd ? pd : 16'h0000;

    compared++;
    if ((got_out & mask) !== (exp_out & mask)) begin
      mismatched++;
      $display("FAIL %s stream: got %h want %h (mask %h)", name, got_out, exp_out, mask);
    end
    compared++;
    if (got_t !== exp_t) begin
      mismatched++;
      $display("FAIL %s mdioT: got %h want %h", name, got_t, exp_t);
    end
    compared++;
    if (mdc_bad != 0 || hold_bad != 0) begin
      mismatched++;
      $display("FAIL %s bit_timing: %0d bad mdc cycles, %0d mid-bit output changes, want 0/0",
               name, mdc_bad, hold_bad);
    end
    compared++;
    if (early_rv != 0 || rdy_bad != 0 || busy_bad != 0) begin
      mismatched++;
      $display("FAIL %s in_frame: rspValid=1 %0d, cmdReady=1 %0d, busy=0 %0d cycles, want 0/0/0",
               name, early_rv, rdy_bad, busy_bad);
    end
    compared++;
    if ({rspValid, busy, mdc, mdioT, mdioOut, cmdReady} !== 6'b110110) begin
      mismatched++;
      $display("FAIL %s done_cycle: rv/busy/mdc/T/out/rdy=%b want 110110",
               name, {rspValid, busy, mdc, mdioT, mdioOut, cmdReady});
    end
    compared++;
    if (rspData !== exp_data || rspTaErr !== (rd & ta2)) begin
      mismatched++;
      $display("FAIL %s response: data=%h taerr=%b want data=%h taerr=%b",
               name, rspData, rspTaErr, exp_data, rd & ta2);
    end
    @(negedge clk);
    compared++;
    if ({cmdReady, busy, rspValid} !== 3'b100 || rspData !== exp_data) begin
      mismatched++;
      $display("FAIL %s after_done: rdy/busy/rv=%b data=%h want 100 data=%h",
               name, {cmdReady, busy, rspValid}, rspData, exp_data);
    end
  endtask

  task automatic test_spec_write();
    int w;
    run_frame("spec_write", 1'b0, 5'h01, 5'h04, 16'hA5C3, 1'b0, 16'h0, 1'b0, w);
  endtask

  task automatic test_spec_read();
    int w;
    run_frame("spec_read", 1'b1, 5'h1F, 5'h02, 16'h0, 1'b0, 16'h1234, 1'b0, w);
  endtask

  task automatic test_pullup_read();
    int w;
    run_frame("pullup_read", 1'b1, 5'h07, 5'h11, 16'h0, 1'b1, 16'hFFFF, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("random%0d", i), 1'($urandom), 5'($urandom), 5'($urandom),
                16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0, w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    run_frame("b2b_first", 1'b0, 5'h03, 5'h1C, 16'h0F0F, 1'b0, 16'h0, 1'b1, w);
    run_frame("b2b_second", 1'b1, 5'h12, 5'h05, 16'h0, 1'b0, 16'hBEEF, 1'b0, w);
    compared++;
    if (w != 0) begin
      mismatched++;
      $display("FAIL b2b_accept_wait: second command waited %0d cycles, want 0", w);
    end
  endtask

  task automatic test_reset_midframe();
    int wait_cyc, rv_seen, busy_seen;
    wait_cyc = 0; rv_seen = 0; busy_seen = 0;
    cmdValid = 1'b1; cmdRead = 1'b0; cmdPhyAddr = 5'h05; cmdRegAddr = 5'h09; cmdWrData = 16'h5A5A;
    while (cmdReady !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    cmdValid = 1'b0;
    repeat (40 * 2 * D) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({mdc, mdioT, mdioOut, busy, rspValid, cmdReady} !== 6'b011000 || rspData !== 16'h0) begin
      mismatched++;
      $display("FAIL midframe_reset: mdc/T/out/busy/rv/rdy=%b data=%h want 011000 0000",
               {mdc, mdioT, mdioOut, busy, rspValid, cmdReady}, rspData);
    end
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rspValid !== 1'b0) rv_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    compared++;
    if (rv_seen != 0 || busy_seen != 0) begin
      mismatched++;
      $display("FAIL midframe_aborted: rspValid cycles=%0d busy cycles=%0d want 0/0", rv_seen, busy_seen);
    end
    run_frame("after_reset", 1'b0, 5'h1E, 5'h01, 16'hC0DE, 1'b0, 16'h0, 1'b0, wait_cyc);
  endtask

  task automatic test_slow_div();
    int wait_cyc, run, runs, bad, done_c;
    logic prev;
    wait_cyc = 0; run = 0; runs = 0; bad = 0; done_c = -1; prev = 1'b0;
    s_cmdValid = 1'b1; s_cmdRead = 1'b0; s_cmdPhyAddr = 5'h0A; s_cmdRegAddr = 5'h15; s_cmdWrData = 16'h3C96;
    while (s_cmdReady !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    compared++;
    if (s_cmdReady !== 1'b1) begin
      mismatched++;
      $display("FAIL slow_accept: cmdReady=%b want 1", s_cmdReady);
      s_cmdValid = 1'b0;
      return;
    end
    @(negedge clk);
    s_cmdValid = 1'b0;
    for (int c = 0; c <= 128 * DS; c++) begin
      if (s_mdc !== prev) begin
        runs++;
        if (run != DS) bad++;
        run  = 0;
        prev = s_mdc;
      end
      run++;
      if (s_rspValid === 1'b1 && done_c < 0) done_c = c;
      if (c < 128 * DS) @(negedge clk);
    end
    compared++;
    if (runs != 128 || bad != 0) begin
      mismatched++;
      $display("FAIL slow_mdc_phases: %0d phases, %0d not %0d cycles long; want 128 phases, 0 bad",
               runs, bad, DS);
    end
    compared++;
    if (done_c != 128 * DS || {s_busy, s_mdioT, s_rspTaErr} !== 3'b110 || s_rspData !== 16'h0) begin
      mismatched++;
      $display("FAIL slow_done: rspValid at +%0d busy/T/taerr=%b data=%h want +%0d 110 0000",
               done_c + 1, {s_busy, s_mdioT, s_rspTaErr}, s_rspData, 128 * DS + 1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_spec_write();
    test_spec_read();
    test_pullup_read();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_slow_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 20: MDC half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have a single clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cmdValid  in  1  command request.
REQ-006 cmdReady  out  1  command accepted when cmdValid&&cmdReady.
REQ-007 cmdRead  in  1  1=read frame, 0=write frame.
REQ-008 cmdPhyAddr  in  5  PHY address.
REQ-009 cmdRegAddr  in  5  register address.
REQ-010 cmdWrData  in  16  write data; ignored for reads.
REQ-011 rspValid  out  1  one-cycle pulse at frame completion.
REQ-012 rspData  out  16  read data; 0 after writes; held until next rspValid.
REQ-013 rspTaErr  out  1  read turnaround error; valid with rspValid.
REQ-014 busy  out  1  frame in progress.
REQ-015 mdc  out  1  management clock to pin.
REQ-016 mdioOut  out  1  data to IO buffer input.
REQ-017 mdioT  out  1  IO buffer tristate; 1=high-Z.
REQ-018 mdioIn  in  1  data from IO buffer output (pin value).

Function
REQ-019 SHALL implement states IDLE, PRE, HDR, TA, DATA, DONE; IDLE->PRE on accept; PRE->HDR after 32 bits; HDR->TA after 14 bits; TA->DATA after 2 bits; DATA->DONE after 16 bits; DONE->IDLE after one cycle.
REQ-020 cmdReady SHALL be 1 only in IDLE; cmdValid outside IDLE is ignored and never queued.
REQ-021 On accept, all cmd fields SHALL be latched; later input changes do not affect the frame.
REQ-022 A bit period SHALL be 2*CLK_DIV cycles: mdc low for the first CLK_DIV cycles, high for the next CLK_DIV.
REQ-023 mdioOut/mdioT SHALL update only on the first cycle of each bit period (mdc low phase).
REQ-024 mdioIn SHALL be sampled on the cycle mdc goes 0->1.
REQ-025 Frame bit order SHALL be: 32x '1'; ST '01'; OP '10' read / '01' write; PHY addr MSB first; REG addr MSB first; TA; 16 data bits MSB first.
REQ-026 Write TA SHALL drive '10' with mdioT=0; write data SHALL be driven with mdioT=0.
REQ-027 Read TA and read DATA SHALL set mdioT=1; second TA bit sampled, rspTaErr=1 if it reads 1; DATA bits shifted into rspData MSB first.
REQ-028 mdioT SHALL be 0 for PRE and HDR bits of all frames.
REQ-029 Accept in cycle N: busy=1 and first preamble bit driven from N+1; rspValid=1 in cycle N+1+128*CLK_DIV (DONE); cmdReady=1 and busy=0 from the next cycle.
REQ-030 In IDLE and DONE: mdc=0, mdioT=1, mdioOut=1.
REQ-031 rspTaErr SHALL be 0 after write frames; rspData SHALL be 0 after write frames.
REQ-032 Bit counter and divider counter SHALL not wrap mid-frame; a new command accepted in the cycle cmdReady returns starts a fresh frame with counters at 0.

Reset
REQ-033 rst SHALL force within one cycle: state IDLE, mdc=0, mdioT=1, mdioOut=1, busy=0, rspValid=0, rspData=0, rspTaErr=0, cmdReady=0 during rst, cmdReady=1 the cycle after rst deasserts.
REQ-034 rst mid-frame SHALL abort with no rspValid; the aborted command is discarded.

Verification
REQ-035 CLK_DIV=2, write PHY=0x01 REG=0x04 data=0xA5C3 -> serial stream 32x1,01,01,00001,00100,10,1010010111000011; mdioT=0 all 64 bits; rspValid at N+257; rspData=0.
REQ-036 CLK_DIV=2, read PHY=0x1F REG=0x02, PHY model drives TA '0' on bit 2 then 0x1234 -> mdioT=1 from bit 46; rspData=0x1234, rspTaErr=0.
REQ-037 Read with PHY model leaving line high (pull-up, mdioIn=1) -> rspData=0xFFFF, rspTaErr=1.
REQ-038 cmdValid held high across two commands -> second accepted only in cycle after rspValid; no cycle with cmdReady=1 while busy=1.
REQ-039 rst asserted at bit 40 of a write -> next cycle mdc=0, mdioT=1, busy=0; no rspValid; following command completes normally.
REQ-040 CLK_DIV=255 -> mdc high/low phases exactly 255 cycles each; frame completes at N+1+32640.
